// File: rtl/amo_pkg.sv
// Shared types for the atomic memory initiator: op codes, FSM states and the
// read-modify-write arithmetic.
package amo_pkg;
  `include "tags.svh"

  typedef enum logic [3:0] {
    AMO_OP_LR   = 4'd0,
    AMO_OP_SC   = 4'd1,
    AMO_OP_SWAP = 4'd2,
    AMO_OP_ADD  = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_AND  = 4'd5,
    AMO_OP_OR   = 4'd6,
    AMO_OP_MIN  = 4'd7,
    AMO_OP_MAX  = 4'd8,
    AMO_OP_MINU = 4'd9,
    AMO_OP_MAXU = 4'd10
  } amo_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    GAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } amo_state_e;

  // Ties in min/max keep the old value so an equal compare never rewrites memory content.
  function automatic logic [31:0] amo_alu_fn(input amo_op_e op, input logic [31:0] old_v,
                                             input logic [31:0] rs2_v);
    logic [31:0] r;
    r = old_v;
    case (op)
      AMO_OP_SWAP: r = rs2_v;
      AMO_OP_ADD:  r = old_v + rs2_v;
      AMO_OP_XOR:  r = old_v ^ rs2_v;
      AMO_OP_AND:  r = old_v & rs2_v;
      AMO_OP_OR:   r = old_v | rs2_v;
      AMO_OP_MIN:  r = ($signed(rs2_v) < $signed(old_v)) ? rs2_v : old_v;
      AMO_OP_MAX:  r = ($signed(rs2_v) > $signed(old_v)) ? rs2_v : old_v;
      AMO_OP_MINU: r = (rs2_v < old_v) ? rs2_v : old_v;
      AMO_OP_MAXU: r = (rs2_v > old_v) ? rs2_v : old_v;
      default:     r = old_v;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic: new value written back by the read-modify-write.
module amo_alu
  import amo_pkg::*;
(
  input  amo_op_e     op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] new_o
);
  assign new_o = amo_alu_fn(op_i, old_i, rs2_i);
endmodule

// File: rtl/tags.svh
// Address-tag encodings carried on addr_tag_o; the RAM bus uses them to pick
// LR/SC reservation handling or AMO read-modify-write locking.
`ifndef TAGS_SVH
`define TAGS_SVH
localparam int ADDR_TAG_BITS = 2;
localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_MODE_NONE = 2'd0;
localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_MODE_LRSC = 2'd1;
localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_MODE_AMO  = 2'd2;
`endif

// File: rtl/amo_initiator.sv
// Bus initiator for lr.w / sc.w / AMO*: issues tagged read and/or write phases,
// does the AMO arithmetic between them and returns rd to the core.
module amo_initiator
  import amo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [3:0]               op_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              rs2_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [31:0]              rd_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [3:0]               sel_o,
  output logic [31:0]              addr_o,
  output logic [ADDR_TAG_BITS-1:0] addr_tag_o,
  output logic [31:0]              data_o,
  input  logic                     ack_i,
  input  logic [31:0]              data_i,
  input  logic                     data_tag_i
);
  amo_state_e state_q, state_d;
  amo_op_e    op_q, op_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] old_q, old_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        upd_q, upd_d;
  logic        err_pend_q, err_pend_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [ADDR_TAG_BITS-1:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rd_q, rd_d;
  logic        done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [31:0] new_value;
  logic        timeout_hit;
  amo_op_e     op_in;

  amo_alu u_alu (
    .op_i  (op_q),
    .old_i (old_q),
    .rs2_i (rs2_q),
    .new_o (new_value)
  );

  assign op_in       = amo_op_e'(op_i);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs2_d      = rs2_q;
    old_d      = old_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    upd_d      = upd_q;
    err_pend_d = err_pend_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    data_d     = data_q;
    rd_d       = rd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          op_d       = op_in;
          rs2_d      = rs2_i;
          cnt_d      = '0;
          busy_d     = 1'b1;
          upd_d      = 1'b0;
          err_pend_d = 1'b0;
          if (addr_i[1:0] != 2'b00) begin
            res_d      = '0;
            upd_d      = 1'b1;
            err_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            sel_d  = 4'hF;
            addr_d = {addr_i[31:2], 2'b00};
            if (op_in == AMO_OP_SC) begin
              we_d    = 1'b1;
              tag_d   = ADDR_TAG_MODE_LRSC;
              data_d  = rs2_i;
              state_d = WR;
            end else begin
              we_d    = 1'b0;
              tag_d   = (op_in == AMO_OP_LR) ? ADDR_TAG_MODE_LRSC : ADDR_TAG_MODE_AMO;
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (stb_q && ack_i) begin
          old_d = data_i;
          stb_d = 1'b0;
          if (op_q == AMO_OP_LR) begin
            cyc_d   = 1'b0;
            res_d   = data_i;
            upd_d   = 1'b1;
            state_d = DONE;
          end else begin
            // cyc stays high through GAP so the RAM bus keeps the location locked
            state_d = GAP;
          end
        end else if (timeout_hit) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          err_pend_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        data_d  = new_value;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        tag_d   = ADDR_TAG_MODE_AMO;
        cnt_d   = '0;
        state_d = WR;
      end
      WR: begin
        if (stb_q && ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          res_d   = (op_q == AMO_OP_SC) ? {31'b0, data_tag_i} : old_q;
          upd_d   = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          err_pend_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = err_pend_q;
        if (upd_q) rd_d = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= AMO_OP_LR;
      rs2_q      <= '0;
      old_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      upd_q      <= 1'b0;
      err_pend_q <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs2_q      <= rs2_d;
      old_q      <= old_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      upd_q      <= upd_d;
      err_pend_q <= err_pend_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rd_o       = rd_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = stb_q;
  assign we_o       = we_q;
  assign sel_o      = sel_q;
  assign addr_o     = addr_q;
  assign addr_tag_o = tag_q;
  assign data_o     = data_q;
endmodule

// File: tb/tb_amo_initiator.sv
// Self-checking bench: a small RAM-bus responder, a table of AMO vectors,
// hand-written corner sequences and randomized ops against a reference model.
module tb_amo_initiator;
  import amo_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] rs2_i = '0;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [31:0] rd_o, addr_o, data_o;
  logic [3:0]  sel_o;
  logic [ADDR_TAG_BITS-1:0] addr_tag_o;
  logic        ack_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        data_tag_i = 1'b0;

  always #5 clk = ~clk;

  amo_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .addr_i(addr_i),
    .rs2_i(rs2_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_o(rd_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .addr_o(addr_o),
    .addr_tag_o(addr_tag_o), .data_o(data_o), .ack_i(ack_i), .data_i(data_i),
    .data_tag_i(data_tag_i)
  );

  logic [31:0] mem [16];
  int  wait_cfg = 0, wait_cnt = 0;
  bit  stuck = 0, sc_fail = 0;
  int  stb_cnt = 0, gap_cnt = 0, rd_cnt = 0, wr_cnt = 0, sel_bad = 0;
  logic [1:0]  last_rd_tag = '0, last_wr_tag = '0;
  logic [31:0] last_wr_data = '0;
  int  vectors = 0, miscompares = 0;

  // RAM-bus model: ack in the same cycle as stb after wait_cfg extra cycles;
  // failed SC stores are suppressed and flagged on data_tag_i.
  always @(negedge clk) begin
    ack_i = 1'b0;
    data_tag_i = 1'b0;
    if (cyc_o && stb_o) begin
      stb_cnt++;
      if (sel_o != 4'hF) sel_bad++;
      if (!stuck) begin
        if (wait_cnt < wait_cfg) wait_cnt++;
        else begin
          wait_cnt = 0;
          ack_i = 1'b1;
          if (!we_o) begin
            data_i = mem[addr_o[5:2]];
            rd_cnt++;
            last_rd_tag = addr_tag_o;
          end else begin
            wr_cnt++;
            last_wr_tag = addr_tag_o;
            last_wr_data = data_o;
            if (addr_tag_o == ADDR_TAG_MODE_LRSC && sc_fail) data_tag_i = 1'b1;
            else mem[addr_o[5:2]] = data_o;
          end
        end
      end
    end else begin
      wait_cnt = 0;
      if (cyc_o) gap_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    op_i = op; addr_i = addr; rs2_i = rs2; start_i = 1'b1;
    stb_cnt = 0; gap_cnt = 0;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done_o) check("done_seen", 32'(done_o), 32'd1);
    rd = rd_o;
    err = err_o;
    $display("txn op=%0d addr=%08h rs2=%08h rd=%08h err=%0d lat=%0d", op, addr, rs2, rd, err, lat);
  endtask

  // Reference arithmetic stated directly from the AMO rules.
  function automatic logic [31:0] ref_new(input logic [3:0] op, input logic [31:0] old_v,
                                          input logic [31:0] rs2_v);
    int signed sa, sb;
    longint ua, ub;
    sa = old_v; sb = rs2_v;
    ua = longint'({32'd0, old_v}); ub = longint'({32'd0, rs2_v});
    case (op)
      4'd2:  return rs2_v;
      4'd3:  return old_v + rs2_v;
      4'd4:  return old_v ^ rs2_v;
      4'd5:  return old_v & rs2_v;
      4'd6:  return old_v | rs2_v;
      4'd7:  return (sa <= sb) ? old_v : rs2_v;
      4'd8:  return (sa >= sb) ? old_v : rs2_v;
      4'd9:  return (ua <= ub) ? old_v : rs2_v;
      4'd10: return (ua >= ub) ? old_v : rs2_v;
      default: return old_v;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] old_v;
    logic [31:0] rs2;
    logic [31:0] exp_mem;
  } amo_vec_t;

  amo_vec_t vecs [11];

  initial begin
    logic [31:0] rd, prev_rd;
    logic err;
    int lat, rd0, wr0, done_seen, found;

    vecs[0]  = '{4'd3,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[4]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[5]  = '{4'd2,  32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_CCDD};
    vecs[6]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[7]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[8]  = '{4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[9]  = '{4'd7,  32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
    vecs[10] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_done", 32'(done_o), 0);
    check("reset_cyc_stb", {30'd0, cyc_o, stb_o}, 0);
    check("reset_rd", rd_o, 0);
    check("reset_tag_sel", {26'd0, addr_tag_o, sel_o}, 0);

    // LR, zero-wait
    mem[0] = 32'hDEAD_BEEF;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(4'd0, 32'h0000_1000, 32'h0, rd, err, lat);
    check("lr_rd", rd, 32'hDEAD_BEEF);
    check("lr_lat", 32'(lat), 3);
    check("lr_err", 32'(err), 0);
    check("lr_reads", 32'(rd_cnt - rd0), 1);
    check("lr_writes", 32'(wr_cnt - wr0), 0);
    check("lr_tag", 32'(last_rd_tag), 32'(ADDR_TAG_MODE_LRSC));
    check("lr_gap", 32'(gap_cnt), 0);

    // SC success then failure
    sc_fail = 0;
    run_op(4'd1, 32'h0000_1000, 32'h55, rd, err, lat);
    check("sc_ok_rd", rd, 0);
    check("sc_ok_data", last_wr_data, 32'h55);
    check("sc_ok_tag", 32'(last_wr_tag), 32'(ADDR_TAG_MODE_LRSC));
    check("sc_ok_mem", mem[0], 32'h55);
    check("sc_ok_lat", 32'(lat), 3);
    sc_fail = 1;
    run_op(4'd1, 32'h0000_1000, 32'h66, rd, err, lat);
    check("sc_fail_rd", rd, 1);
    check("sc_fail_err", 32'(err), 0);
    check("sc_fail_mem", mem[0], 32'h55);
    sc_fail = 0;

    // AMO vector table
    foreach (vecs[i]) begin
      mem[0] = vecs[i].old_v;
      run_op(vecs[i].op, 32'h0000_2000, vecs[i].rs2, rd, err, lat);
      check($sformatf("amo%0d_rd", i), rd, vecs[i].old_v);
      check($sformatf("amo%0d_mem", i), mem[0], vecs[i].exp_mem);
      check($sformatf("amo%0d_lat", i), 32'(lat), 5);
      check($sformatf("amo%0d_err", i), 32'(err), 0);
      check($sformatf("amo%0d_tags", i), {last_rd_tag, last_wr_tag},
            {ADDR_TAG_MODE_AMO, ADDR_TAG_MODE_AMO});
      check($sformatf("amo%0d_gap", i), 32'(gap_cnt), 1);
    end

    // Misaligned address
    prev_rd = rd_o;
    check("mis_prev_nonzero", 32'(prev_rd != 0), 1);
    run_op(4'd3, 32'h0000_1002, 32'h1, rd, err, lat);
    check("mis_stb", 32'(stb_cnt), 0);
    check("mis_err", 32'(err), 1);
    check("mis_rd", rd, 0);
    check("mis_lat", 32'(lat), 2);

    // Timeouts in RD (AMO) and WR (SC)
    mem[1] = 32'hCAFE_F00D;
    run_op(4'd0, 32'h0000_1004, 32'h0, rd, err, lat);
    check("pre_to_rd", rd, 32'hCAFE_F00D);
    stuck = 1;
    wr0 = wr_cnt;
    run_op(4'd3, 32'h0000_1004, 32'h1, rd, err, lat);
    check("to_rd_stb", 32'(stb_cnt), TO);
    check("to_rd_err", 32'(err), 1);
    check("to_rd_rd", rd, 32'hCAFE_F00D);
    check("to_rd_lat", 32'(lat), TO + 2);
    check("to_rd_writes", 32'(wr_cnt - wr0), 0);
    run_op(4'd1, 32'h0000_1004, 32'h9, rd, err, lat);
    check("to_wr_stb", 32'(stb_cnt), TO);
    check("to_wr_err", 32'(err), 1);
    stuck = 0;

    // Reset during the AMO GAP cycle
    mem[2] = 32'h0000_0010;
    wr0 = wr_cnt;
    @(negedge clk);
    op_i = 4'd3; addr_i = 32'h0000_2008; rs2_i = 32'h1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (cyc_o && !stb_o) found = 1;
      else @(negedge clk);
    end
    check("gap_reached", 32'(found), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_gap_cyc_stb", {30'd0, cyc_o, stb_o}, 0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_o || stb_o) done_seen++;
    end
    check("rst_gap_no_done", 32'(done_seen), 0);
    check("rst_gap_no_write", 32'(wr_cnt - wr0), 0);
    check("rst_gap_mem", mem[2], 32'h0000_0010);
    check("rst_gap_busy", 32'(busy_o), 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      logic [31:0] addr, rs2, old_v, exp_rd, exp_mem;
      int idx, w, exp_lat;
      bit mis, exp_err;
      op  = 4'($urandom_range(0, 10));
      idx = int'($urandom_range(0, 15));
      mis = ($urandom_range(0, 7) == 0);
      addr = 32'h3000 + 32'(idx * 4) + (mis ? 32'($urandom_range(1, 3)) : 32'd0);
      old_v = mem[idx];
      rs2 = ($urandom_range(0, 3) == 0) ? old_v : 32'($urandom);
      w = int'($urandom_range(0, 3));
      wait_cfg = w;
      sc_fail = bit'($urandom_range(0, 1));
      exp_mem = old_v; exp_err = 0;
      if (mis) begin
        exp_rd = 0; exp_err = 1; exp_lat = 2;
      end else if (op == 4'd0) begin
        exp_rd = old_v; exp_lat = 3 + w;
      end else if (op == 4'd1) begin
        exp_rd = sc_fail ? 32'd1 : 32'd0;
        exp_mem = sc_fail ? old_v : rs2;
        exp_lat = 3 + w;
      end else begin
        exp_rd = old_v; exp_mem = ref_new(op, old_v, rs2); exp_lat = 5 + 2 * w;
      end
      run_op(op, addr, rs2, rd, err, lat);
      check($sformatf("rnd%0d_rd", n), rd, exp_rd);
      check($sformatf("rnd%0d_err", n), 32'(err), 32'(exp_err));
      check($sformatf("rnd%0d_mem", n), mem[idx], exp_mem);
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
    end

    check("sel_all_ones", 32'(sel_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
